// File: rtl/sram_mr1w.sv
// Parametrised multi-read, single-write working memory with byte-enabled writes,
// write-first read bypass and a hardware zero-fill sequencer.
module sram_mr1w #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192,
    parameter int NUM_RD = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear_req,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t              state, nextState;
    logic [ADDR_W-1:0]   clrCnt, nextClrCnt;

    logic                memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memData;
    logic [BE_W-1:0]     memBe;
    logic                wrInRange;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign wrInRange = ({1'b0, wr_addr} < DEPTH_X);
    assign busy      = (state == CLEAR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else begin
            state  <= nextState;
            clrCnt <= nextClrCnt;
        end
    end

    // The sweep owns the single write port while clearing; user writes share it in IDLE.
    always_comb begin
        nextState  = state;
        nextClrCnt = clrCnt;
        memWe      = 1'b0;
        memAddr    = wr_addr;
        memData    = wr_data;
        memBe      = wr_be;
        case (state)
            CLEAR: begin
                memWe   = 1'b1;
                memAddr = clrCnt;
                memData = '0;
                memBe   = '1;
                if (clrCnt == LAST_ADDR) begin
                    nextState  = IDLE;
                    nextClrCnt = '0;
                end else begin
                    nextClrCnt = clrCnt + 1'b1;
                end
            end
            IDLE: begin
                memWe = we && wrInRange;
                if (clear_req) begin
                    nextState = CLEAR;
                end
            end
            default: nextState = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (memWe) begin
            for (int unsigned k = 0; k < BE_W; k++) begin
                if (memBe[k]) begin
                    mem[memAddr][8*k +: 8] <= memData[8*k +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic              inRange;
        logic              hit;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] dataQ;
        logic              validQ;

        assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
        assign inRange = ({1'b0, addr} < DEPTH_X);
        assign hit     = we && (wr_addr == addr);

        // Merge enabled write bytes over the stored word so a colliding read sees post-write data.
        always_comb begin
            word = '0;
            if (inRange) begin
                word = mem[addr];
                if (hit) begin
                    for (int unsigned k = 0; k < BE_W; k++) begin
                        if (wr_be[k]) begin
                            word[8*k +: 8] = wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                validQ <= 1'b0;
                dataQ  <= '0;
            end else if (state == IDLE) begin
                validQ <= rd_en[p];
                if (rd_en[p]) begin
                    dataQ <= word;
                end
            end else begin
                validQ <= 1'b0;
            end
        end

        assign rd_valid[p]                   = validQ;
        assign rd_data[p*DATA_W +: DATA_W]   = dataQ;
    end

endmodule

// File: tb/tb_sram_mr1w.sv
// Directed bench for sram_mr1w: a 16-deep instance for most checks and a
// 12-deep instance sharing the same stimulus for out-of-range behaviour.
module tb_sram_mr1w;

    logic         clock;
    logic         reset_n;
    logic         clear_req;
    logic         we;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic [1:0]   rd_en;
    logic [7:0]   rd_addr;

    logic         busyA, busyB;
    logic [255:0] rdDataA, rdDataB;
    logic [1:0]   rdValidA, rdValidB;

    int tests  = 0;
    int failed = 0;

    sram_mr1w #(.DATA_W(128), .ADDR_W(4), .DEPTH(16), .NUM_RD(2)) dutA (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busyA),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdDataA), .rd_valid(rdValidA)
    );

    sram_mr1w #(.DATA_W(128), .ADDR_W(4), .DEPTH(12), .NUM_RD(2)) dutB (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busyB),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdDataB), .rd_valid(rdValidB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         we;
        logic [3:0]   wa;
        logic [127:0] wd;
        logic [15:0]  be;
        logic [1:0]   ren;
        logic [3:0]   ra0;
        logic [3:0]   ra1;
        logic [1:0]   expV;
        logic [127:0] exp0;
        logic [127:0] exp1;
    } vec_t;

    vec_t vecs[10];

    localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AABB;
    localparam logic [127:0] W2 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1122;
    localparam logic [127:0] M5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AA22;
    localparam logic [127:0] O3 = {16{8'hA5}};
    localparam logic [127:0] Q4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] D3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] M3 = 128'hA5A5_A5A5_A5A5_A5A5_5555_6666_7777_8888;
    localparam logic [127:0] X13 = 128'hCAFE_BABE_DEAD_BEEF_0BAD_F00D_1234_5678;
    localparam logic [127:0] ONES = {128{1'b1}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        clear_req = 1'b0;
        we        = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        rd_en     = '0;
        rd_addr   = '0;
    endtask

    // Counts edges from reset release until each instance drops busy (0 = never within bound).
    task automatic countBusy(input string tag);
        int doneA = 0;
        int doneB = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!busyA && doneA == 0) doneA = i;
            if (!busyB && doneB == 0) doneB = i;
        end
        check({tag, " busy cycles A"}, 128'(doneA), 128'd16);
        check({tag, " busy cycles B"}, 128'(doneB), 128'd12);
    endtask

    function automatic vec_t mk(logic w, logic [3:0] wa, logic [127:0] wd, logic [15:0] be,
                                logic [1:0] ren, logic [3:0] ra0, logic [3:0] ra1,
                                logic [1:0] expV, logic [127:0] e0, logic [127:0] e1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.be = be; v.ren = ren;
        v.ra0 = ra0; v.ra1 = ra1; v.expV = expV; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(1, 4'd5, W1,   16'hFFFF, 2'b00, 4'd0, 4'd0, 2'b00, '0, '0);
        vecs[1] = mk(1, 4'd5, W2,   16'h0001, 2'b00, 4'd0, 4'd0, 2'b00, '0, '0);
        vecs[2] = mk(0, 4'd0, '0,   16'h0000, 2'b01, 4'd5, 4'd0, 2'b01, M5, '0);
        vecs[3] = mk(1, 4'd3, O3,   16'hFFFF, 2'b00, 4'd0, 4'd0, 2'b00, M5, '0);
        vecs[4] = mk(1, 4'd4, Q4,   16'hFFFF, 2'b00, 4'd0, 4'd0, 2'b00, M5, '0);
        vecs[5] = mk(1, 4'd3, D3,   16'h00FF, 2'b11, 4'd4, 4'd3, 2'b11, Q4, M3);
        vecs[6] = mk(0, 4'd0, '0,   16'h0000, 2'b11, 4'd3, 4'd3, 2'b11, M3, M3);
        vecs[7] = mk(1, 4'd5, ONES, 16'h0000, 2'b11, 4'd3, 4'd5, 2'b11, M3, M5);
        vecs[8] = mk(0, 4'd0, '0,   16'h0000, 2'b10, 4'd0, 4'd4, 2'b10, M3, Q4);
        vecs[9] = mk(0, 4'd0, '0,   16'h0000, 2'b00, 4'd0, 4'd0, 2'b00, M3, Q4);

        idleInputs();
        reset_n = 1'b0;

        // Reset state and initial clear length
        repeat (3) tick();
        check("reset busyA", 128'(busyA), 128'd1);
        check("reset busyB", 128'(busyB), 128'd1);
        check("reset validA", 128'(rdValidA), 128'd0);
        check("reset dataA", rdDataA[127:0], '0);
        reset_n = 1'b1;
        countBusy("init");

        // Every word reads back zero after the sweep
        for (int i = 0; i < 16; i++) begin
            rd_en   = 2'b01;
            rd_addr = {4'd0, 4'(i)};
            tick();
            check($sformatf("clr valid a%0d", i), 128'(rdValidA), 128'd1);
            check($sformatf("clr data a%0d", i), rdDataA[127:0], '0);
        end
        idleInputs();
        tick();
        check("valid drops", 128'(rdValidA), 128'd0);

        // Byte-enable writes, collision bypass, hold behaviour
        for (int i = 0; i < 10; i++) begin
            we      = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            wr_be   = vecs[i].be;
            rd_en   = vecs[i].ren;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            check($sformatf("vec%0d valid", i), 128'(rdValidA), 128'(vecs[i].expV));
            check($sformatf("vec%0d d0", i), rdDataA[127:0], vecs[i].exp0);
            check($sformatf("vec%0d d1", i), rdDataA[255:128], vecs[i].exp1);
        end
        idleInputs();

        // clear_req mid-traffic; a second request during the sweep is ignored
        we = 1'b1; wr_addr = 4'd7; wr_data = 128'h1234; wr_be = 16'hFFFF;
        tick();
        idleInputs();
        rd_en = 2'b01; rd_addr = 8'h07;
        tick();
        check("pre-clear a7", rdDataA[127:0], 128'h1234);
        idleInputs();
        clear_req = 1'b1;
        tick();
        check("clear_req busy", 128'(busyA), 128'd1);
        for (int i = 1; i <= 16; i++) begin
            clear_req = (i == 8);
            we = 1'b1; wr_addr = 4'd7; wr_data = ONES; wr_be = 16'hFFFF;
            rd_en = 2'b11; rd_addr = 8'h77;
            tick();
            check($sformatf("sweep valid c%0d", i), 128'(rdValidA), 128'd0);
            check($sformatf("sweep busy c%0d", i), 128'(busyA), (i < 16) ? 128'd1 : 128'd0);
        end
        idleInputs();
        rd_en = 2'b01; rd_addr = 8'h07;
        tick();
        check("post-clear valid", 128'(rdValidA), 128'd1);
        check("post-clear a7", rdDataA[127:0], '0);
        idleInputs();

        // Out-of-range on the 12-deep instance
        we = 1'b1; wr_addr = 4'd13; wr_data = X13; wr_be = 16'hFFFF;
        tick();
        idleInputs();
        rd_en = 2'b11; rd_addr = {4'd11, 4'd13};
        tick();
        check("oor validB", 128'(rdValidB), 128'd3);
        check("oor B a13", rdDataB[127:0], '0);
        check("oor B a11", rdDataB[255:128], '0);
        check("inrange A a13", rdDataA[127:0], X13);
        rd_en = 2'b11; rd_addr = {4'd9, 4'd1};
        tick();
        check("oor B a1", rdDataB[127:0], '0);
        check("oor B a9", rdDataB[255:128], '0);
        idleInputs();

        // Reset during an active read
        rd_en = 2'b01; rd_addr = 8'h0D;
        tick();
        check("pre-reset a13", rdDataA[127:0], X13);
        idleInputs();
        #2 reset_n = 1'b0;
        #1;
        check("mid-read rst busy", 128'(busyA), 128'd1);
        check("mid-read rst valid", 128'(rdValidA), 128'd0);
        check("mid-read rst data", rdDataA[127:0], '0);
        tick();
        reset_n = 1'b1;

        // Reset during the sweep restarts it from the beginning
        repeat (5) tick();
        check("mid-clear busy", 128'(busyA), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid-clear rst busy", 128'(busyA), 128'd1);
        check("mid-clear rst valid", 128'(rdValidA), 128'd0);
        tick();
        reset_n = 1'b1;
        countBusy("restart");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
